// File: rtl/lcd_serial_pkg.sv
// Shared types, init table and panel command codes for the LCD serial sequencer.
package lcd_serial_pkg;

    typedef enum logic [2:0] {
        ST_RST_LCD,
        ST_RST_WAIT,
        ST_INIT,
        ST_WIN,
        ST_PIX
    } state_t;

    typedef enum logic [1:0] {
        K_CMD   = 2'd0,
        K_DATA  = 2'd1,
        K_DELAY = 2'd2,
        K_END   = 2'd3
    } kind_t;

    typedef struct packed {
        kind_t      kind;
        logic [7:0] value;
    } rom_entry_t;

    localparam logic [7:0] CASET = 8'h2A;
    localparam logic [7:0] RASET = 8'h2B;
    localparam logic [7:0] RAMWR = 8'h2C;

    localparam rom_entry_t INIT_ROM [0:7] = '{
        '{kind: K_CMD,   value: 8'h01},
        '{kind: K_DELAY, value: 8'd150},
        '{kind: K_CMD,   value: 8'h11},
        '{kind: K_DELAY, value: 8'd255},
        '{kind: K_CMD,   value: 8'h3A},
        '{kind: K_DATA,  value: 8'h05},
        '{kind: K_CMD,   value: 8'h29},
        '{kind: K_END,   value: 8'h00}
    };

endpackage

// File: rtl/lcd_serial_seq_timer.sv
// Loadable down-counter; done while the count sits at zero.
module lcd_seq_timer #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/lcd_serial_seq.sv
// Panel reset, init table playback and endless frame streaming
// into a byte-wide valid/ready serial transmitter.
module lcd_serial_seq
    import lcd_serial_pkg::*;
#(
    parameter int SERIAL_BITS   = 8,
    parameter int PIXEL_BITS    = 16,
    parameter int SCREEN_WIDTH  = 128,
    parameter int SCREEN_HEIGHT = 160,
    parameter int RESET_CYCLES  = 1000,
    parameter int DELAY_UNIT    = 1000,
    localparam int XW = (SCREEN_WIDTH > 1) ? $clog2(SCREEN_WIDTH) : 1,
    localparam int YW = (SCREEN_HEIGHT > 1) ? $clog2(SCREEN_HEIGHT) : 1
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_tx_ready,
    output logic                   out_tx_valid,
    output logic [SERIAL_BITS-1:0] out_tx_data,
    output logic                   out_tx_dc,
    output logic                   out_vid_rst,
    output logic [XW-1:0]          out_pixel_x,
    output logic [YW-1:0]          out_pixel_y,
    input  logic [PIXEL_BITS-1:0]  in_pixel,
    output logic                   out_frame_start,
    output logic                   out_init_done
);

    localparam int NB = PIXEL_BITS / SERIAL_BITS;
    localparam int BW = (NB > 1) ? $clog2(NB) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(SCREEN_WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(SCREEN_HEIGHT - 1);

    state_t state, state_d;

    logic [2:0]             idx;
    logic [3:0]             win_cnt;
    logic [BW-1:0]          byte_cnt;
    logic [XW-1:0]          x;
    logic [YW-1:0]          y;
    logic [PIXEL_BITS-1:0]  pix_sr;
    logic                   armed;
    logic                   init_done;
    logic                   tx_valid;
    logic [SERIAL_BITS-1:0] tx_data;
    logic                   tx_dc;
    logic                   tx_ramwr;

    logic                   load_en;
    logic                   emit;
    logic [SERIAL_BITS-1:0] e_data;
    logic                   e_dc;
    logic                   e_ramwr;
    logic                   idx_inc;
    logic                   arm_set;
    logic                   arm_clr;
    logic                   init_set;
    logic                   t_load;
    logic [31:0]            t_val;
    logic                   t_done;
    logic                   last_byte;
    logic                   go;
    rom_entry_t             ent;
    logic [31:0]            dly;

    lcd_seq_timer #(.W(32)) u_timer (
        .clk      (in_clk),
        .rst_n    (in_rst),
        .load     (t_load),
        .load_val (t_val),
        .done     (t_done)
    );

    // Output register refills whenever empty or being drained.
    assign load_en   = !tx_valid || in_tx_ready;
    assign go        = emit && load_en;
    assign ent       = INIT_ROM[idx];
    assign dly       = 32'(ent.value) * 32'(DELAY_UNIT);
    assign last_byte = (byte_cnt == BW'(NB - 1));

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            state <= ST_RST_LCD;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        emit     = 1'b0;
        e_data   = '0;
        e_dc     = 1'b0;
        e_ramwr  = 1'b0;
        idx_inc  = 1'b0;
        arm_set  = 1'b0;
        arm_clr  = 1'b0;
        init_set = 1'b0;
        t_load   = 1'b0;
        t_val    = '0;
        unique case (state)
            ST_RST_LCD: begin
                if (!armed) begin
                    t_load  = 1'b1;
                    t_val   = 32'(RESET_CYCLES - 2);
                    arm_set = 1'b1;
                end else if (t_done) begin
                    t_load  = 1'b1;
                    t_val   = 32'(RESET_CYCLES - 1);
                    arm_clr = 1'b1;
                    state_d = ST_RST_WAIT;
                end
            end
            ST_RST_WAIT: begin
                if (t_done) state_d = ST_INIT;
            end
            ST_INIT: begin
                unique case (ent.kind)
                    K_CMD, K_DATA: begin
                        emit    = 1'b1;
                        e_data  = SERIAL_BITS'(ent.value);
                        e_dc    = ent.kind[0];
                        idx_inc = load_en;
                    end
                    K_DELAY: begin
                        if (!armed) begin
                            if (ent.value == 8'd0) begin
                                idx_inc = 1'b1;
                            end else begin
                                t_load  = 1'b1;
                                t_val   = (dly > 32'd1) ? dly - 32'd2 : 32'd0;
                                arm_set = 1'b1;
                            end
                        end else if (t_done) begin
                            idx_inc = 1'b1;
                            arm_clr = 1'b1;
                        end
                    end
                    K_END: begin
                        init_set = 1'b1;
                        state_d  = ST_WIN;
                    end
                endcase
            end
            ST_WIN: begin
                emit = 1'b1;
                e_dc = 1'b1;
                unique case (win_cnt)
                    4'd0: begin
                        e_data = SERIAL_BITS'(CASET);
                        e_dc   = 1'b0;
                    end
                    4'd4: e_data = SERIAL_BITS'(8'(SCREEN_WIDTH - 1));
                    4'd5: begin
                        e_data = SERIAL_BITS'(RASET);
                        e_dc   = 1'b0;
                    end
                    4'd9: e_data = SERIAL_BITS'(8'(SCREEN_HEIGHT - 1));
                    4'd10: begin
                        e_data  = SERIAL_BITS'(RAMWR);
                        e_dc    = 1'b0;
                        e_ramwr = 1'b1;
                    end
                    default: e_data = '0;
                endcase
                if (load_en && win_cnt == 4'd10) state_d = ST_PIX;
            end
            ST_PIX: begin
                emit = 1'b1;
                e_dc = 1'b1;
                if (byte_cnt == '0) begin
                    e_data = in_pixel[PIXEL_BITS-1 -: SERIAL_BITS];
                end else begin
                    e_data = pix_sr[PIXEL_BITS-1 -: SERIAL_BITS];
                end
                if (load_en && last_byte && x == X_LAST && y == Y_LAST) begin
                    state_d = ST_WIN;
                end
            end
            default: state_d = ST_RST_LCD;
        endcase
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            idx       <= '0;
            win_cnt   <= '0;
            byte_cnt  <= '0;
            x         <= '0;
            y         <= '0;
            pix_sr    <= '0;
            armed     <= 1'b0;
            init_done <= 1'b0;
            tx_valid  <= 1'b0;
            tx_data   <= '0;
            tx_dc     <= 1'b0;
            tx_ramwr  <= 1'b0;
        end else begin
            if (load_en) begin
                tx_valid <= emit;
                if (emit) begin
                    tx_data  <= e_data;
                    tx_dc    <= e_dc;
                    tx_ramwr <= e_ramwr;
                end
            end
            if (idx_inc) idx <= idx + 3'd1;
            if (arm_set) begin
                armed <= 1'b1;
            end else if (arm_clr) begin
                armed <= 1'b0;
            end
            if (init_set) init_done <= 1'b1;
            if (go && state == ST_WIN) begin
                win_cnt <= (win_cnt == 4'd10) ? 4'd0 : win_cnt + 4'd1;
            end
            // First byte of a pixel snapshots the source; later bytes shift out.
            if (go && state == ST_PIX) begin
                if (byte_cnt == '0) begin
                    pix_sr <= in_pixel << SERIAL_BITS;
                end else begin
                    pix_sr <= pix_sr << SERIAL_BITS;
                end
                if (last_byte) begin
                    byte_cnt <= '0;
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= (y == Y_LAST) ? '0 : y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end else begin
                    byte_cnt <= byte_cnt + 1'b1;
                end
            end
        end
    end

    assign out_tx_valid    = tx_valid;
    assign out_tx_data     = tx_data;
    assign out_tx_dc       = tx_dc;
    assign out_vid_rst     = (state != ST_RST_LCD);
    assign out_pixel_x     = x;
    assign out_pixel_y     = y;
    assign out_frame_start = tx_valid && in_tx_ready && tx_ramwr;
    assign out_init_done   = init_done;

endmodule

// File: tb/tb_lcd_serial_seq.sv
// Directed bench for lcd_serial_seq on a 4x4 panel with short reset
// and delay units; all transferred bytes are logged and compared.
module tb_lcd_serial_seq;

    localparam int RC = 8;
    localparam int DU = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        ready = 1'b1;
    logic        tx_valid;
    logic [7:0]  tx_data;
    logic        tx_dc;
    logic        vid_rst;
    logic [1:0]  px;
    logic [1:0]  py;
    logic [15:0] pixel;
    logic        frame_start;
    logic        init_done;
    logic        pix_mode = 1'b0;
    logic        bp_en = 1'b0;

    always #5 clk = ~clk;

    assign pixel = pix_mode ? {6'd0, py, 6'd0, px} : 16'h2A05;

    lcd_serial_seq #(
        .SERIAL_BITS   (8),
        .PIXEL_BITS    (16),
        .SCREEN_WIDTH  (4),
        .SCREEN_HEIGHT (4),
        .RESET_CYCLES  (RC),
        .DELAY_UNIT    (DU)
    ) dut (
        .in_clk          (clk),
        .in_rst          (rst_n),
        .in_tx_ready     (ready),
        .out_tx_valid    (tx_valid),
        .out_tx_data     (tx_data),
        .out_tx_dc       (tx_dc),
        .out_vid_rst     (vid_rst),
        .out_pixel_x     (px),
        .out_pixel_y     (py),
        .in_pixel        (pixel),
        .out_frame_start (frame_start),
        .out_init_done   (init_done)
    );

    int checks = 0;
    int errs = 0;
    int cyc = 0;

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) cyc++;

    always begin
        @(posedge clk);
        #1;
        if (bp_en) ready = 1'($urandom_range(0, 1));
    end

    logic [7:0] q_data[$];
    bit         q_dc[$];
    bit         q_fs[$];
    bit         q_done[$];
    int         q_vs[$];
    int         q_tc[$];
    int         fs_cnt;
    bit         mon_en = 1'b0;
    bit         pv, pr, pdc;
    logic [7:0] pd;
    int         vs;

    always @(negedge clk) begin
        if (mon_en) begin
            if (pv && !pr) begin
                check("hold", {tx_valid, tx_dc, tx_data}, {1'b1, pdc, pd});
            end
            if (tx_valid && !(pv && !pr)) vs = cyc;
            if (frame_start) fs_cnt++;
            if (tx_valid && ready) begin
                q_data.push_back(tx_data);
                q_dc.push_back(tx_dc);
                q_fs.push_back(frame_start);
                q_done.push_back(init_done);
                q_vs.push_back(vs);
                q_tc.push_back(cyc + 1);
            end
            pv  = tx_valid;
            pr  = ready;
            pdc = tx_dc;
            pd  = tx_data;
        end else begin
            pv = 1'b0;
        end
    end

    function automatic logic [8:0] exp_byte(input int k, input bit mode);
        logic [15:0] pix;
        int p;
        case (k)
            0:  return {1'b0, 8'h2A};
            4:  return {1'b1, 8'h03};
            5:  return {1'b0, 8'h2B};
            9:  return {1'b1, 8'h03};
            10: return {1'b0, 8'h2C};
            1, 2, 3, 6, 7, 8: return {1'b1, 8'h00};
            default: begin
                p = (k - 11) / 2;
                pix = mode ? {8'(p / 4), 8'(p % 4)} : 16'h2A05;
                return {1'b1, ((k - 11) % 2 == 0) ? pix[15:8] : pix[7:0]};
            end
        endcase
    endfunction

    int rise;

    task automatic reset_checks();
        check("rst_valid", tx_valid, 0);
        check("rst_data", tx_data, 0);
        check("rst_dc", tx_dc, 0);
        check("rst_vid_rst", vid_rst, 0);
        check("rst_xy", {px, py}, 0);
        check("rst_fs", frame_start, 0);
        check("rst_done", init_done, 0);
    endtask

    task automatic start_run(input bit mode, input bit bp);
        int lo;
        mon_en = 1'b0;
        rst_n = 1'b0;
        q_data.delete();
        q_dc.delete();
        q_fs.delete();
        q_done.delete();
        q_vs.delete();
        q_tc.delete();
        fs_cnt = 0;
        pix_mode = mode;
        bp_en = 1'b0;
        ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset_checks();
        rst_n = 1'b1;
        mon_en = 1'b1;
        bp_en = bp;
        lo = 0;
        @(negedge clk);
        check("done_after_rst", init_done, 0);
        while (!vid_rst && lo < 100) begin
            lo++;
            @(negedge clk);
        end
        check("vid_rst_low", lo, RC);
        rise = cyc;
    endtask

    task automatic wait_tx(input int n);
        int b = 0;
        while (q_data.size() < n && b < 20000) begin
            @(negedge clk);
            b++;
        end
        check("tx_avail", q_data.size() >= n, 1);
    endtask

    task automatic check_frames(input int base, input int nf, input bit mode);
        for (int f = 0; f < nf; f++) begin
            for (int k = 0; k < 43; k++) begin
                int i = base + 43 * f + k;
                check("frame_byte", {q_dc[i], q_data[i]}, exp_byte(k, mode));
                check("frame_fs", q_fs[i], (k == 10) ? 1 : 0);
            end
        end
    endtask

    logic [8:0] init_exp [5] = '{9'h001, 9'h011, 9'h03A, 9'h105, 9'h029};

    initial begin
        int gap;
        // Run A: ready held high, constant pixel
        start_run(1'b0, 1'b0);
        wait_tx(92);
        check("first_after_vidrst", (q_vs[0] - rise) >= RC, 1);
        for (int i = 0; i < 5; i++) begin
            check("init_byte", {q_dc[i], q_data[i]}, init_exp[i]);
        end
        gap = q_vs[1] - q_tc[0];
        check("gap_150", (gap >= 599 && gap <= 601) ? 600 : gap, 600);
        gap = q_vs[2] - q_tc[1];
        check("gap_255", (gap >= 1019 && gap <= 1021) ? 1020 : gap, 1020);
        check("done_before_end", q_done[4], 0);
        check("done_after_end", q_done[5], 1);
        check_frames(5, 2, 1'b0);
        check("next_frame", {q_dc[91], q_data[91]}, {1'b0, 8'h2A});
        check("fs_count", fs_cnt, 2);

        // Run B: coordinate pixels under random backpressure
        start_run(1'b1, 1'b1);
        wait_tx(92);
        bp_en = 1'b0;
        ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("bp_init_byte", {q_dc[i], q_data[i]}, init_exp[i]);
        end
        check_frames(5, 2, 1'b1);
        check("pix_2nd", {q_data[18], q_data[19]}, 16'h0001);
        check("pix_5th", {q_data[24], q_data[25]}, 16'h0100);
        check("pix_last", {q_data[46], q_data[47]}, 16'h0303);
        check("bp_next_frame", {q_dc[91], q_data[91]}, {1'b0, 8'h2A});

        // Run C: asynchronous reset 20 bytes into the pixel stream
        start_run(1'b0, 1'b0);
        wait_tx(36);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        reset_checks();
        start_run(1'b0, 1'b0);
        wait_tx(1);
        check("restart_byte", {q_dc[0], q_data[0]}, 9'h001);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs);
        $finish;
    end

endmodule

// File: doc/lcd_serial_seq.md
Name: lcd_serial_seq

Overview:
Sequencer that drives the byte-wide serial LCD transmitter. Pulses the panel hardware reset, plays a fixed init table of commands, data bytes and delays, then streams frames forever. Each frame is window setup, RAMWR, then WIDTH*HEIGHT pixels fetched from a pixel source by (x,y), split into bytes MSB first. Sits between the pixel generator (testpattern or framebuffer) and the serial shift module, replacing the ad-hoc sequencing inside the video serial top.

Parameters:
SERIAL_BITS, 8, bits per transmitted byte
PIXEL_BITS, 16, pixel width; must be a multiple of SERIAL_BITS
SCREEN_WIDTH, 128, pixels per row (<=256)
SCREEN_HEIGHT, 160, rows (<=256)
RESET_CYCLES, 1000, clocks out_vid_rst is held low, and clocks waited after release
DELAY_UNIT, 1000, clocks per init-table delay count

Ports:
in_clk  in  1  system clock
in_rst  in  1  reset; asynchronous, active-low
in_tx_ready  in  1  transmitter accepts a byte this cycle
out_tx_valid  out  1  byte present on out_tx_data
out_tx_data  out  SERIAL_BITS  byte to shift out
out_tx_dc  out  1  0 = command, 1 = data; qualified by out_tx_valid
out_vid_rst  out  1  panel reset, active-low
out_pixel_x  out  $clog2(SCREEN_WIDTH)  pixel column requested
out_pixel_y  out  $clog2(SCREEN_HEIGHT)  pixel row requested
in_pixel  in  PIXEL_BITS  pixel at (x,y), combinational from source
out_frame_start  out  1  one-cycle pulse when RAMWR of a frame is accepted
out_init_done  out  1  high once the init table has finished; sticky until reset

Behaviour:
- Reset (in_rst=0): state RST_LCD; out_vid_rst=0, out_tx_valid=0, out_tx_data=0, out_tx_dc=0, x=y=0, out_frame_start=0, out_init_done=0, all counters 0.
- Handshake: a byte transfers on a rising edge with out_tx_valid&&in_tx_ready. Once valid is raised, data, dc and valid stay stable until that transfer. Valid may be asserted in the cycle after a transfer (back-to-back at 1 byte/clock when ready is held high).
- Init ROM entry format, 10 bits: [9:8] kind (0 CMD, 1 DATA, 2 DELAY, 3 END), [7:0] value. Contents in order: CMD 0x01; DELAY 150; CMD 0x11; DELAY 255; CMD 0x3A; DATA 0x05; CMD 0x29; END.
- States:
  - RST_LCD: out_vid_rst=0 for RESET_CYCLES clocks, then go to RST_WAIT.
  - RST_WAIT: out_vid_rst=1 for RESET_CYCLES clocks, then go to INIT with rom index 0.
  - INIT, CMD/DATA entry: present the byte with dc=kind[0]; on transfer, index+1.
  - INIT, DELAY entry: no valid; wait value*DELAY_UNIT clocks, then index+1. A DELAY value of 0 waits 0 clocks and advances the next cycle.
  - INIT, END entry: set out_init_done and go to WIN.
  - WIN: send 11 bytes: 0x2A(cmd), 0,0,0,W-1 (data), 0x2B(cmd), 0,0,0,H-1 (data), 0x2C(cmd). The RAMWR transfer pulses out_frame_start and enters PIX.
  - PIX: for each pixel, send PIXEL_BITS/SERIAL_BITS data bytes, MSB byte first. in_pixel is sampled at the transfer of the first byte of that pixel. x increments after the last byte; on x=W-1 it wraps to 0 and y increments; after (W-1,H-1) set x=y=0 and go to WIN.
- Widths: the W-1/H-1 bytes are truncated to 8 bits. x/y widths are min 1 bit.
- in_tx_ready held low stalls indefinitely with outputs stable. Delay and reset counters run independently of ready.
- Asynchronous reset mid-frame or mid-init aborts immediately to RST_LCD and re-runs the full sequence.

Decomposition:
- Package lcd_serial_pkg: state enum, entry-kind enum, ROM entry typedef, init ROM constant array, command constants (CASET 0x2A, RASET 0x2B, RAMWR 0x2C).
- One natural sub-module: lcd_seq_timer, a loadable down-counter with a done flag. It is shared by the reset and delay waits.

Test Plan:
Common setup: W=H=4, PIXEL_BITS=16, RESET_CYCLES=8, DELAY_UNIT=4.
- Reset release, ready=1: out_vid_rst low for 8 clocks, then high. First valid byte 0x01 with dc=0 appears no earlier than 8 clocks after out_vid_rst rises.
- Delay timing, ready=1: gap between the 0x01 transfer and the 0x11 valid is 150*4=600 clocks (±1). Gap before 0x3A is 1020 clocks. Byte order is 0x3A(dc0), 0x05(dc1), 0x29(dc0). out_init_done rises after END.
- Frame stream, in_pixel=16'h2A05, ready=1: bytes are 2A,00,00,00,03,2B,00,00,00,03,2C, then 16 repeats of 2A,05 (dc=1), then 0x2A again. That is 43 bytes per frame; out_frame_start fires once per frame.
- Coordinates: in_pixel=(y<<8)|x. The second pixel sent is 0x0001; the fifth is 0x0100; the last in the frame is 0x0303.
- Backpressure: toggle in_tx_ready pseudo-randomly. The byte sequence equals the ready=1 case, and data/dc never change while valid&&!ready.
- Reset in PIX after 20 bytes: outputs return to reset values asynchronously. The sequence restarts with out_vid_rst low for 8 clocks and out_init_done=0.
